hamming_scrubber: RTL and testbench

Background memory scrubber for the 12-bit Hamming(12,8) codeword store. On a start pulse it walks every address, reads each stored codeword and recomputes the syndrome. It writes back corrected codewords for single-bit errors and counts both corrected and uncorrectable words. It is the read-side counterpart of the encode/write path and shares the memory port with functional traffic through a req/gnt handshake.

---
 rtl/hamming_scrubber.sv | 209 ++++++++++++++++++++
 tb/tb_hamming_scrubber.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_scrubber.sv
// ---------------------------------------------------------------------------
// hamming_scrubber
//
// Background scrubber for a store of 12-bit Hamming(12,8) codewords. A start
// pulse launches one full pass over every address. Each word is read and its
// syndrome is recomputed. Single-bit errors are written back corrected, and
// uncorrectable syndromes are only counted. The memory port is shared with
// functional traffic, so every access is a req/gnt handshake.
//
// Codeword layout, index 0..11:
//   p1 p2 d0 p4 d1 d2 d3 p8 d4 d5 d6 d7
// The Hamming position of a bit is its index + 1.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle request to begin a pass; only honoured in IDLE
//   abort       synchronous return to IDLE from any state; no done pulse
//   mem_req     memory access request, held until mem_gnt
//   mem_gnt     grant; the access happens on the edge where it is high
//   mem_we      1 = write, 0 = read; meaningful while mem_req is high
//   mem_addr    access address (the scrub pointer)
//   mem_wdata   corrected codeword for write-back
//   mem_rdata   read data, valid in the cycle after a granted read
//   busy        high in READ, WAIT, CHECK and WRITE
//   done        one-cycle pulse when a pass completes
//   corr_cnt    saturating count of corrected words
//   uncorr_cnt  saturating count of uncorrectable words
//   err_addr    address of the most recent corrected/uncorrectable word
// ---------------------------------------------------------------------------
module hamming_scrubber #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr_ptr;
  logic [11:0]       word_q;
  logic [3:0]        syndrome;
  logic [11:0]       flip_mask;
  logic [11:0]       corrected;
  logic              is_clean;
  logic              is_correctable;

  // XOR-ing together the positions of all set bits gives the same result as
  // computing each syndrome bit over the positions that have that bit set.
  function automatic logic [3:0] calc_syndrome(input logic [11:0] cw);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 12; i++) begin
      if (cw[i]) s = s ^ 4'(i + 1);
    end
    return s;
  endfunction

  assign mem_addr = addr_ptr;

  // Classify the captured word. A syndrome of 1..12 names the failing
  // position, whether it is a data or a parity bit. Values 13..15 point
  // past the end of the word and cannot be fixed.
  always_comb begin
    syndrome  = calc_syndrome(word_q);
    flip_mask = '0;
    for (int i = 0; i < 12; i++) begin
      flip_mask[i] = (syndrome == 4'(i + 1));
    end
    corrected      = word_q ^ flip_mask;
    is_clean       = (syndrome == 4'd0);
    is_correctable = !is_clean && (syndrome <= 4'd12);
  end

  // Scrub sequencer. Every output is registered here, so mem_req, mem_we,
  // mem_addr and mem_wdata cannot change while a request waits for its
  // grant. abort is checked first so it pre-empts every transition,
  // including a start in the same cycle and a write that is still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_ptr   <= '0;
      word_q     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      err_addr   <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              addr_ptr   <= '0;
              corr_cnt   <= '0;
              uncorr_cnt <= '0;
              state      <= S_READ;
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              busy       <= 1'b1;
            end
          end

          S_READ: begin
            if (mem_gnt) begin
              mem_req <= 1'b0;
              state   <= S_WAIT;
            end
          end

          S_WAIT: begin
            word_q <= mem_rdata;
            state  <= S_CHECK;
          end

          S_CHECK: begin
            if (is_correctable) begin
              mem_wdata <= corrected;
              err_addr  <= addr_ptr;
              if (corr_cnt != CNT_MAX) corr_cnt <= corr_cnt + 1'b1;
              state   <= S_WRITE;
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
            end else begin
              // An uncorrectable word is recorded but left untouched.
              if (!is_clean) begin
                err_addr <= addr_ptr;
                if (uncorr_cnt != CNT_MAX) uncorr_cnt <= uncorr_cnt + 1'b1;
              end
              if (addr_ptr == LAST_ADDR) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                addr_ptr <= addr_ptr + 1'b1;
                state    <= S_READ;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
              end
            end
          end

          S_WRITE: begin
            if (mem_gnt) begin
              if (addr_ptr == LAST_ADDR) begin
                state   <= S_DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
              end else begin
                addr_ptr <= addr_ptr + 1'b1;
                state    <= S_READ;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
              end
            end
          end

          S_DONE: begin
            state <= S_IDLE;
          end

          default: begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hamming_scrubber.sv
// ---------------------------------------------------------------------------
// tb_hamming_scrubber
//
// Drives hamming_scrubber (ADDR_W=4, CNT_W=2) against a behavioural memory.
// When a corrupted word is planted, the clean codeword the scrubber should
// write back is queued. Every granted write pops the queue and compares
// address and data. Pass-level results (done cycle, counters, err_addr) are
// compared after each pass.
// ---------------------------------------------------------------------------
module tb_hamming_scrubber;

  typedef struct {
    logic [3:0]  addr;
    logic [11:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;
  logic [3:0]  err_addr;

  logic [11:0] mem [16];
  logic [11:0] exp_clean [16];
  wr_t         exp_wr_q [$];
  int          vectors;
  int          miscompares;

  hamming_scrubber #(
    .ADDR_W(4),
    .CNT_W (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .corr_cnt  (corr_cnt),
    .uncorr_cnt(uncorr_cnt),
    .err_addr  (err_addr)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a pass never finishes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference encoder: data bits go to indices 2,4,5,6,8,9,10,11 and each
  // parity bit covers the positions that share its position bit.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] w;
    w     = '0;
    w[2]  = d[0];
    w[4]  = d[1];
    w[5]  = d[2];
    w[6]  = d[3];
    w[8]  = d[4];
    w[9]  = d[5];
    w[10] = d[6];
    w[11] = d[7];
    w[0]  = w[2] ^ w[4] ^ w[6] ^ w[8] ^ w[10];
    w[1]  = w[2] ^ w[5] ^ w[6] ^ w[9] ^ w[10];
    w[3]  = w[4] ^ w[5] ^ w[6] ^ w[11];
    w[7]  = w[8] ^ w[9] ^ w[10] ^ w[11];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: looks at the request just before the edge it will be
  // granted on and commits the access there.
  task automatic serviceMemory();
    wr_t e;
    if (rst_n && mem_req && mem_gnt) begin
      if (mem_we) begin
        checkOutput("wr_expected", (exp_wr_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_wr_q.size() > 0) begin
          e = exp_wr_q.pop_front();
          checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("wr_data", 32'(mem_wdata), 32'(e.data));
        end
        mem[mem_addr] = mem_wdata;
      end else begin
        mem_rdata = mem[mem_addr];
      end
    end
  endtask

  // Advance one clock cycle and return 1 time unit after the rising edge
  task automatic stepCycle();
    @(negedge clk);
    serviceMemory();
    @(posedge clk);
    #1;
  endtask

  task automatic fillClean();
    for (int a = 0; a < 16; a++) mem[a] = 12'hA27;
  endtask

  // Run one pass. start is sampled at edge 0, so the loop index c is the
  // cycle number. A write request can be stalled for several cycles, or
  // aborted; exp_done = 0 means the pass is expected to be aborted.
  task automatic applyStimulus(input string name, input int exp_done,
                               input int stall_cycles, input logic [3:0] stall_addr,
                               input logic [11:0] stall_data,
                               input bit abort_on_write, input bit poke_start);
    int done_cycle = 0;
    int busy_cycles = 0;
    int stall_left = stall_cycles;
    int done_seen = 0;
    bit stalling = 1'b0;
    bit aborted = 1'b0;
    start   = 1'b1;
    mem_gnt = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput({name, "_first_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({name, "_first_req"}, 32'(mem_req), 32'd1);
    checkOutput({name, "_first_we"}, 32'(mem_we), 32'd0);
    checkOutput({name, "_corr_cleared"}, 32'(corr_cnt), 32'd0);
    checkOutput({name, "_uncorr_cleared"}, 32'(uncorr_cnt), 32'd0);
    for (int c = 1; c <= 300; c++) begin
      if (done) begin
        done_cycle = c;
        break;
      end
      if (busy) busy_cycles++;
      start = poke_start && (c == 10 || c == 40);
      if (abort_on_write && mem_req && mem_we) begin
        mem_gnt = 1'b0;
        abort   = 1'b1;
        stepCycle();
        abort   = 1'b0;
        mem_gnt = 1'b1;
        checkOutput({name, "_abort_req"}, 32'(mem_req), 32'd0);
        checkOutput({name, "_abort_busy"}, 32'(busy), 32'd0);
        aborted = 1'b1;
        break;
      end else if (stall_left > 0 && (stalling || (mem_req && mem_we))) begin
        stalling = 1'b1;
        mem_gnt  = 1'b0;
        checkOutput({name, "_stall_req"}, 32'(mem_req), 32'd1);
        checkOutput({name, "_stall_we"}, 32'(mem_we), 32'd1);
        checkOutput({name, "_stall_addr"}, 32'(mem_addr), 32'(stall_addr));
        checkOutput({name, "_stall_wdata"}, 32'(mem_wdata), 32'(stall_data));
        stall_left--;
      end else begin
        mem_gnt = 1'b1;
      end
      stepCycle();
    end
    start   = 1'b0;
    mem_gnt = 1'b1;
    if (exp_done == 0) begin
      checkOutput({name, "_aborted"}, 32'(aborted), 32'd1);
      for (int k = 0; k < 60; k++) begin
        if (done) done_seen++;
        stepCycle();
      end
      checkOutput({name, "_no_done"}, 32'(done_seen), 32'd0);
    end else begin
      checkOutput({name, "_done_cycle"}, 32'(done_cycle), 32'(exp_done));
      checkOutput({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_done - 1));
      stepCycle();
      checkOutput({name, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({name, "_idle_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_writes_left"}, 32'(exp_wr_q.size()), 32'd0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    mem_gnt     = 1'b0;
    mem_rdata   = '0;
    fillClean();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_corr", 32'(corr_cnt), 32'd0);
    checkOutput("rst_uncorr", 32'(uncorr_cnt), 32'd0);
    checkOutput("rst_err_addr", 32'(err_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: all words clean
    applyStimulus("s1", 49, 0, 4'd0, 12'h000, 1'b0, 1'b0);
    checkOutput("s1_corr", 32'(corr_cnt), 32'd0);
    checkOutput("s1_uncorr", 32'(uncorr_cnt), 32'd0);
    checkOutput("s1_err_addr", 32'(err_addr), 32'd0);

    // 2: d2 flipped at address 3 -> syndrome 6, corrected write-back
    mem[3] = 12'hA07;
    exp_wr_q.push_back('{addr: 4'd3, data: 12'hA27});
    applyStimulus("s2", 50, 0, 4'd0, 12'h000, 1'b0, 1'b0);
    checkOutput("s2_corr", 32'(corr_cnt), 32'd1);
    checkOutput("s2_uncorr", 32'(uncorr_cnt), 32'd0);
    checkOutput("s2_err_addr", 32'(err_addr), 32'd3);
    checkOutput("s2_mem3", 32'(mem[3]), 32'h A27);

    // 3: two flips at address 9 -> syndrome 13, left untouched
    mem[9] = 12'h226;
    applyStimulus("s3", 49, 0, 4'd0, 12'h000, 1'b0, 1'b0);
    checkOutput("s3_corr", 32'(corr_cnt), 32'd0);
    checkOutput("s3_uncorr", 32'(uncorr_cnt), 32'd1);
    checkOutput("s3_err_addr", 32'(err_addr), 32'd9);
    checkOutput("s3_mem9", 32'(mem[9]), 32'h226);
    mem[9] = 12'hA27;

    // 4: write-back stalled for 5 cycles
    mem[3] = 12'hA07;
    exp_wr_q.push_back('{addr: 4'd3, data: 12'hA27});
    applyStimulus("s4", 55, 5, 4'd3, 12'hA27, 1'b0, 1'b0);
    checkOutput("s4_corr", 32'(corr_cnt), 32'd1);
    checkOutput("s4_err_addr", 32'(err_addr), 32'd3);
    checkOutput("s4_mem3", 32'(mem[3]), 32'hA27);

    // 5: abort while the write-back waits for its grant, then restart
    mem[3] = 12'hA07;
    applyStimulus("s5", 0, 0, 4'd0, 12'h000, 1'b1, 1'b0);
    checkOutput("s5_no_write", 32'(mem[3]), 32'hA07);
    checkOutput("s5_corr_kept", 32'(corr_cnt), 32'd1);
    exp_wr_q.push_back('{addr: 4'd3, data: 12'hA27});
    applyStimulus("s5r", 50, 0, 4'd0, 12'h000, 1'b0, 1'b0);
    checkOutput("s5r_corr", 32'(corr_cnt), 32'd1);
    checkOutput("s5r_mem3", 32'(mem[3]), 32'hA27);

    // 6: every word has one flipped bit; counter saturates, start pokes ignored
    for (int a = 0; a < 16; a++) begin
      exp_clean[a] = encode(8'($urandom));
      mem[a] = exp_clean[a] ^ (12'd1 << (a % 12));
      exp_wr_q.push_back('{addr: 4'(a), data: exp_clean[a]});
    end
    applyStimulus("s6", 65, 0, 4'd0, 12'h000, 1'b0, 1'b1);
    checkOutput("s6_corr_sat", 32'(corr_cnt), 32'd3);
    checkOutput("s6_uncorr", 32'(uncorr_cnt), 32'd0);
    checkOutput("s6_err_addr", 32'(err_addr), 32'd15);
    for (int a = 0; a < 16; a++) begin
      checkOutput($sformatf("s6_mem%0d", a), 32'(mem[a]), 32'(exp_clean[a]));
    end

    // 7: asynchronous reset in the middle of a pass
    fillClean();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (10) stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s7_req", 32'(mem_req), 32'd0);
    checkOutput("s7_busy", 32'(busy), 32'd0);
    checkOutput("s7_addr", 32'(mem_addr), 32'd0);
    checkOutput("s7_err_addr", 32'(err_addr), 32'd0);
    checkOutput("s7_corr", 32'(corr_cnt), 32'd0);
    checkOutput("s7_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
